// File: rtl/avmm_burst_writer_if.sv
// Avalon-MM burst write bus between avmm_burst_writer (master) and the memory port (slave).
interface avmm_burst_writer_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16
);
    localparam int BC_W = $clog2(MAX_BURST) + 1;

    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [BC_W-1:0]     burstcount;
    logic                write;
    logic                waitrequest;

    modport master (
        output address, writedata, byteenable, burstcount, write,
        input  waitrequest
    );

    modport slave (
        input  address, writedata, byteenable, burstcount, write,
        output waitrequest
    );
endinterface

// File: rtl/avmm_burst_writer.sv
// Avalon-MM burst write master draining a show-ahead FIFO into memory in bursts of up to MAX_BURST beats.
// Define AVMM_WR_4K_SPLIT_EN to also end every burst at the next 4 KiB address boundary.
module avmm_burst_writer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [LEN_W-1:0]  wr_length,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] fifo_q,
    input  logic              fifo_empty,
    output logic              fifo_rdreq,
    avmm_burst_writer_if.master bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int BC_W  = $clog2(MAX_BURST) + 1;
    localparam int REM_W = LEN_W - BSH;

    typedef enum logic [1:0] {IDLE, SETUP, BURST, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] addr_q;
    logic [BC_W-1:0]   bcount_q;
    logic [BC_W-1:0]   beats_left;
    logic [REM_W-1:0]  rem;
    logic [REM_W-1:0]  words_in;
    logic [BC_W-1:0]   blen;
    logic [ADDR_W-1:0] burst_bytes;
    logic              write_c;
    logic              beat_ok;

    assign words_in    = REM_W'(wr_length >> BSH);
    assign burst_bytes = ADDR_W'(bcount_q) << BSH;

    // Data and write strobe come straight from the FIFO head so a beat can issue every cycle.
    assign write_c    = (state == BURST) && !fifo_empty;
    assign beat_ok    = write_c && !bus.waitrequest;
    assign fifo_rdreq = beat_ok;

    assign bus.write      = write_c;
    assign bus.writedata  = fifo_q;
    assign bus.byteenable = '1;
    assign bus.address    = addr_q;
    assign bus.burstcount = bcount_q;

`ifdef AVMM_WR_4K_SPLIT_EN
    logic [12:0] to_bound;
    assign to_bound = (13'h1000 - {1'b0, cur_addr[11:0]}) >> BSH;
`endif

    always_comb begin
        blen = BC_W'(MAX_BURST);
        if (rem < REM_W'(MAX_BURST))
            blen = rem[BC_W-1:0];
`ifdef AVMM_WR_4K_SPLIT_EN
        if (to_bound < 13'(blen))
            blen = to_bound[BC_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            cur_addr   <= '0;
            addr_q     <= '0;
            bcount_q   <= '0;
            beats_left <= '0;
            rem        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr <= wr_address & ~ADDR_W'(BYTES - 1);
                        rem      <= words_in;
                        busy     <= 1'b1;
                        if (words_in == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    addr_q     <= cur_addr;
                    bcount_q   <= blen;
                    beats_left <= blen;
                    state      <= BURST;
                end
                BURST: begin
                    if (beat_ok) begin
                        beats_left <= beats_left - 1'b1;
                        rem        <= rem - 1'b1;
                        if (beats_left == BC_W'(1)) begin
                            cur_addr <= cur_addr + burst_bytes;
                            if (rem == REM_W'(1)) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= SETUP;
                            end
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/avmm_burst_writer.md
# avmm_burst_writer

Parametrised Avalon-MM burst write master that drains a show-ahead FIFO into memory. Software programs a start byte address and a byte length; the block splits the transfer into bursts of at most MAX_BURST beats, sustains one beat per cycle when the FIFO and slave allow, and pulses `done` on completion. It sits between the packet FIFO and the HPS/SDRAM Avalon-MM port, taking over the FIFO-to-memory write path.

## Interface
- DATA_W, 32: data bus width in bits (32, 64 or 128).
- ADDR_W, 32: byte address width.
- MAX_BURST, 16: maximum beats per burst (power of two, 1..256).
- LEN_W, 24: byte-length field width.
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- wr_address  in  ADDR_W  start byte address; DATA_W/8 aligned (low bits ignored).
- wr_length  in  LEN_W  byte count; low log2(DATA_W/8) bits ignored.
- busy  out  1  high from the cycle after an accepted `start` through DONE.
- done  out  1  one-cycle completion pulse.
- fifo_q  in  DATA_W  show-ahead FIFO head word, valid when !fifo_empty.
- fifo_empty  in  1  FIFO empty.
- fifo_rdreq  out  1  pop head word.
- address  out  ADDR_W  Avalon burst base address.
- writedata  out  DATA_W  Avalon write data.
- byteenable  out  DATA_W/8  constant all ones.
- burstcount  out  log2(MAX_BURST)+1  beats in current burst.
- write  out  1  Avalon write request.
- waitrequest  in  1  Avalon stall.

## Operation
- States: IDLE, SETUP, BURST, DONE.
- IDLE: `start` latches base address and word count `wr_length >> log2(DATA_W/8)` into internal registers; -> SETUP. Word count 0 -> DONE directly (no bus activity).
- SETUP: burst length = min(remaining words, MAX_BURST), written to `burstcount`, `address` = current address, beat counter loaded; -> BURST.
- BURST: `write` = !fifo_empty; `writedata` = fifo_q (combinational pass-through); `fifo_rdreq` = write & !waitrequest. A beat is accepted when write & !waitrequest; beat counter and remaining count decrement per accepted beat. FIFO empty mid-burst deasserts `write` (legal Avalon bubble); `address`/`burstcount` held constant for the whole burst.
- Last beat accepted: current address += burst beats × DATA_W/8; remaining > 0 -> SETUP, else -> DONE.
- DONE: `done` = 1 for one cycle; -> IDLE.
- `start` outside IDLE ignored; inputs wr_address/wr_length are don't-care after the latch cycle.
- Arithmetic: address adds wrap modulo 2^ADDR_W; remaining counter width LEN_W − log2(DATA_W/8).

## Timing
- Reset values: busy 0, done 0, write 0, fifo_rdreq 0, address 0, burstcount 0, writedata follows fifo_q; state IDLE, counters 0.
- Reset mid-burst: next edge forces IDLE and write 0; no completion of the partial burst (system-wide reset only).
- start at cycle T -> SETUP at T+1 -> first possible `write` at T+2.
- Throughput: 1 beat/cycle inside a burst; 1 idle SETUP cycle between bursts.
- Last beat at cycle L -> `done` high at L+1 (DONE), busy low at L+2.
- waitrequest and fifo_empty together: write follows fifo_empty, no pop; no beat lost or duplicated.

## Configuration
- AVMM_WR_4K_SPLIT_EN defined: SETUP burst length additionally limited to words remaining before the next 4 KiB address boundary, so no burst crosses 4 KiB.
- Not defined: burst length = min(remaining, MAX_BURST) only; boundary logic removed.

## Test plan
- Length 64 B, DATA_W=32, MAX_BURST=16, FIFO full, no waitrequest -> one burst, burstcount 16, 16 consecutive write cycles, done 1 cycle after last beat.
- Length 200 B, MAX_BURST=16 -> bursts of 16,16,16,2 at addresses base, +64, +128, +192; 50 pops total.
- Random waitrequest (50 %) and FIFO underflow gaps -> memory model holds exactly the FIFO sequence, address/burstcount stable within each burst.
- wr_length 0 -> no write, done at T+1.
- With AVMM_WR_4K_SPLIT_EN, base 0x0FF8, length 32 B -> bursts of 2 @0x0FF8 then 6 @0x1000.
- Reset low during beat 5 of 16 -> write 0 next cycle, busy 0; new start then completes normally.
